// File: rtl/router_port_tx_pkg.sv
// Shared definitions for the router port serializer: FSM state encoding,
// byte width and the idle levels of the active-low serial lines.
package router_port_tx_pkg;

  localparam int BYTE_W = 8;

  // Idle line levels, shared with the output-side deserializer.
  localparam logic IDLE_FRAME_N = 1'b1;
  localparam logic IDLE_VALID_N = 1'b1;
  localparam logic IDLE_DIN     = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_PAD  = 3'd2,
    ST_DATA = 3'd3,
    ST_WAIT = 3'd4
  } tx_state_e;

endpackage

// File: rtl/router_port_tx.sv
// Source-side serializer for one router input port. Takes an address plus a
// byte stream on valid/ready and emits frame_n / valid_n / din for one
// crossbar input lane.
//
// Handshake: a byte moves when s_valid && s_ready in the same rising edge.
// s_ready is combinational from state only (never from s_valid); the source
// may raise or drop s_valid at any time, and bytes offered while s_ready is
// low are simply not taken.
//
// All line outputs are flops computed from the next state, so a byte
// accepted at edge T puts its first line symbol on the pins right after T.
module router_port_tx
  import router_port_tx_pkg::*;
#(
  parameter int ADDR_W     = 2,
  parameter int PAD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              frame_n,
  output logic              valid_n,
  output logic              din,
  output logic              busy,
  output logic              pkt_done
);

  localparam int AC_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
  localparam int PC_W = (PAD_CYCLES > 0) ? $clog2(PAD_CYCLES + 1) : 1;
  localparam logic [AC_W-1:0] ADDR_LAST = AC_W'(ADDR_W - 1);
  localparam logic [PC_W-1:0] PAD_LAST  = PC_W'((PAD_CYCLES > 0) ? PAD_CYCLES - 1 : 0);

  tx_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BYTE_W-1:0]  shift_q, shift_d;   // PISO: bit 0 is the bit on the line
  logic               last_q, last_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [AC_W-1:0]    addr_cnt_q, addr_cnt_d;
  logic [PC_W-1:0]    pad_cnt_q, pad_cnt_d;
  logic               frame_n_q, frame_n_d;
  logic               valid_n_q, valid_n_d;
  logic               din_q, din_d;
  logic               busy_q, busy_d;
  logic               pkt_done_q, pkt_done_d;

  // Next state, datapath and next line symbol; counters clear outside their state.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    last_d     = last_q;
    bit_cnt_d  = '0;
    addr_cnt_d = '0;
    pad_cnt_d  = '0;
    frame_n_d  = IDLE_FRAME_N;
    valid_n_d  = IDLE_VALID_N;
    din_d      = IDLE_DIN;
    pkt_done_d = 1'b0;
    s_ready    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          addr_d    = s_addr;
          shift_d   = s_data;
          last_d    = s_last;
          state_d   = ST_ADDR;
          frame_n_d = 1'b0;
          din_d     = s_addr[0];
        end
      end

      ST_ADDR: begin
        frame_n_d = 1'b0;
        if (addr_cnt_q == ADDR_LAST) begin
          if (PAD_CYCLES > 0) begin
            state_d = ST_PAD;
          end else begin
            state_d   = ST_DATA;
            valid_n_d = 1'b0;
            din_d     = shift_q[0];
          end
        end else begin
          addr_cnt_d = addr_cnt_q + 1'b1;
          din_d      = addr_q[addr_cnt_d];
        end
      end

      ST_PAD: begin
        frame_n_d = 1'b0;
        if (pad_cnt_q == PAD_LAST) begin
          state_d   = ST_DATA;
          valid_n_d = 1'b0;
          din_d     = shift_q[0];
        end else begin
          pad_cnt_d = pad_cnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (bit_cnt_q != 3'd7) begin
          // Next bit of the current byte; bit 7 of the last byte closes the frame.
          bit_cnt_d  = bit_cnt_q + 1'b1;
          shift_d    = shift_q >> 1;
          din_d      = shift_q[1];
          valid_n_d  = 1'b0;
          frame_n_d  = last_q && (bit_cnt_q == 3'd6);
          pkt_done_d = last_q && (bit_cnt_q == 3'd6);
        end else if (last_q) begin
          state_d = ST_IDLE;
        end else begin
          s_ready   = 1'b1;
          frame_n_d = 1'b0;
          if (s_valid) begin
            shift_d   = s_data;
            last_d    = s_last;
            valid_n_d = 1'b0;
            din_d     = s_data[0];
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        s_ready   = 1'b1;
        frame_n_d = 1'b0;
        if (s_valid) begin
          shift_d   = s_data;
          last_d    = s_last;
          state_d   = ST_DATA;
          valid_n_d = 1'b0;
          din_d     = s_data[0];
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Datapath, counters and registered line outputs; reset forces the idle line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      shift_q    <= '0;
      last_q     <= 1'b0;
      bit_cnt_q  <= '0;
      addr_cnt_q <= '0;
      pad_cnt_q  <= '0;
      frame_n_q  <= IDLE_FRAME_N;
      valid_n_q  <= IDLE_VALID_N;
      din_q      <= IDLE_DIN;
      busy_q     <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      bit_cnt_q  <= bit_cnt_d;
      addr_cnt_q <= addr_cnt_d;
      pad_cnt_q  <= pad_cnt_d;
      frame_n_q  <= frame_n_d;
      valid_n_q  <= valid_n_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  assign frame_n  = frame_n_q;
  assign valid_n  = valid_n_q;
  assign din      = din_q;
  assign busy     = busy_q;
  assign pkt_done = pkt_done_q;

endmodule

// File: tb/tb_router_port_tx.sv
// Bench for router_port_tx: one instance with two pad cycles, one with none.
// A reference model turns each accepted byte into a queue of expected line
// symbols {frame_n, valid_n, din, pkt_done}; an empty queue mid-packet means
// a gap, an empty queue outside a packet means the idle line.
module tb_router_port_tx;

  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] s_addr;
  logic [7:0]        s_data;
  logic              s_last;
  logic              s_valid_a, s_valid_b;
  logic              s_ready_a, frame_n_a, valid_n_a, din_a, busy_a, pkt_done_a;
  logic              s_ready_b, frame_n_b, valid_n_b, din_b, busy_b, pkt_done_b;

  router_port_tx #(.ADDR_W(ADDR_W), .PAD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .s_addr(s_addr), .s_data(s_data), .s_last(s_last),
    .s_valid(s_valid_a), .s_ready(s_ready_a), .frame_n(frame_n_a),
    .valid_n(valid_n_a), .din(din_a), .busy(busy_a), .pkt_done(pkt_done_a)
  );

  router_port_tx #(.ADDR_W(ADDR_W), .PAD_CYCLES(0)) dut_nopad (
    .clk(clk), .rst(rst), .s_addr(s_addr), .s_data(s_data), .s_last(s_last),
    .s_valid(s_valid_b), .s_ready(s_ready_b), .frame_n(frame_n_b),
    .valid_n(valid_n_b), .din(din_b), .busy(busy_b), .pkt_done(pkt_done_b)
  );

  // Clock and reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [3:0] exp_q[$];   // {frame_n, valid_n, din, pkt_done}
  bit         in_pkt    = 1'b0;
  bit         last_seen = 1'b0;
  int         pad       = 2;
  bit         sel       = 1'b0;   // 0: checks dut, 1: checks dut_nopad

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: check pins against the model, then drive the
  // next inputs and feed any accept into the model.
  task automatic model_cycle(input bit v_req, input bit force_last);
    logic [3:0] sym;
    bit         exp_rdy, ends;
    logic       fn, vn, dn, pd, rdy, bz;
    fn  = sel ? frame_n_b  : frame_n_a;
    vn  = sel ? valid_n_b  : valid_n_a;
    dn  = sel ? din_b      : din_a;
    pd  = sel ? pkt_done_b : pkt_done_a;
    rdy = sel ? s_ready_b  : s_ready_a;
    bz  = sel ? busy_b     : busy_a;
    if (exp_q.size() > 0) sym = exp_q.pop_front();
    else                  sym = in_pkt ? 4'b0110 : 4'b1110;
    check("frame_n", 8'(fn), 8'(sym[3]));
    check("valid_n", 8'(vn), 8'(sym[2]));
    check("din", 8'(dn), 8'(sym[1]));
    check("pkt_done", 8'(pd), 8'(sym[0]));
    check("busy", 8'(bz), 8'(in_pkt));
    exp_rdy = !in_pkt || (!last_seen && exp_q.size() == 0);
    check("s_ready", 8'(rdy), 8'(exp_rdy));
    ends = sym[0];

    s_data = 8'($urandom);
    s_addr = ADDR_W'($urandom);
    s_last = force_last || ($urandom_range(0, 2) == 0);
    if (sel) s_valid_b = v_req;
    else     s_valid_a = v_req;

    if (v_req && exp_rdy) begin
      if (!in_pkt) begin
        for (int i = 0; i < ADDR_W; i++) exp_q.push_back({1'b0, 1'b1, s_addr[i], 1'b0});
        for (int i = 0; i < pad; i++)    exp_q.push_back(4'b0110);
        in_pkt = 1'b1;
      end
      for (int i = 0; i < 8; i++) begin
        exp_q.push_back({s_last && (i == 7), 1'b0, s_data[i], s_last && (i == 7)});
      end
      last_seen = s_last;
    end
    if (ends) in_pkt = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (in_pkt || exp_q.size() > 0); i++) begin
      model_cycle(1'b1, 1'b1);
      @(negedge clk);
    end
    check("drain_timeout", 8'(in_pkt), 8'd0);
  endtask

  logic exp_din [13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    rst = 1'b1; s_valid_a = 1'b0; s_valid_b = 1'b0;
    s_addr = '0; s_data = '0; s_last = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state, with and without reset held
    check("rst_frame_n", 8'(frame_n_a), 8'd1);
    check("rst_valid_n", 8'(valid_n_a), 8'd1);
    check("rst_din", 8'(din_a), 8'd1);
    check("rst_busy", 8'(busy_a), 8'd0);
    check("rst_pkt_done", 8'(pkt_done_a), 8'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_frame_n", 8'(frame_n_a), 8'd1);
    check("idle_valid_n", 8'(valid_n_a), 8'd1);
    check("idle_din", 8'(din_a), 8'd1);
    check("idle_s_ready", 8'(s_ready_a), 8'd1);
    check("idle_busy", 8'(busy_a), 8'd0);

    // Single-byte packet: addr 2'b10, 0xA5 last, accepted at c0
    s_addr = 2'b10; s_data = 8'hA5; s_last = 1'b1; s_valid_a = 1'b1;
    @(negedge clk);
    s_valid_a = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      check($sformatf("pkt_din_c%0d", c), 8'(din_a), 8'(exp_din[c-1]));
      check($sformatf("pkt_frame_n_c%0d", c), 8'(frame_n_a), 8'(c >= 12));
      check($sformatf("pkt_valid_n_c%0d", c), 8'(valid_n_a), 8'(!(c >= 5 && c <= 12)));
      check($sformatf("pkt_done_c%0d", c), 8'(pkt_done_a), 8'(c == 12));
      check($sformatf("pkt_busy_c%0d", c), 8'(busy_a), 8'(c <= 12));
      check($sformatf("pkt_s_ready_c%0d", c), 8'(s_ready_a), 8'(c == 13));
      @(negedge clk);
    end

    // Random traffic, two pad cycles
    for (int i = 0; i < 800; i++) begin
      model_cycle($urandom_range(0, 3) != 0, 1'b0);
      @(negedge clk);
    end
    drain();

    // Reset while data bit 3 is on the line
    model_cycle(1'b1, 1'b0);
    @(negedge clk);
    for (int c = 1; c <= 7; c++) begin
      model_cycle(1'b0, 1'b0);
      @(negedge clk);
    end
    check("pre_rst_valid_n", 8'(valid_n_a), 8'd0);
    check("pre_rst_frame_n", 8'(frame_n_a), 8'd0);
    rst = 1'b1;
    #1;
    check("async_rst_frame_n", 8'(frame_n_a), 8'd1);
    check("async_rst_valid_n", 8'(valid_n_a), 8'd1);
    check("async_rst_din", 8'(din_a), 8'd1);
    check("async_rst_busy", 8'(busy_a), 8'd0);
    check("async_rst_pkt_done", 8'(pkt_done_a), 8'd0);
    exp_q.delete(); in_pkt = 1'b0; last_seen = 1'b0;
    @(negedge clk);
    check("held_rst_pkt_done", 8'(pkt_done_a), 8'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      model_cycle($urandom_range(0, 3) != 0, 1'b0);
      @(negedge clk);
    end
    drain();
    s_valid_a = 1'b0;

    // No pad cycles, mostly back-to-back traffic
    sel = 1'b1; pad = 0;
    for (int i = 0; i < 800; i++) begin
      model_cycle($urandom_range(0, 7) != 0, 1'b0);
      @(negedge clk);
    end
    drain();
    s_valid_b = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
